// File: rtl/pmem_hs_ctrl_pkg.sv
// pmem_pkg: FSM state type, LFSR seed and the pmem_* access functions.
// dpi_pmem_* are served by an in-package word memory model.
package pmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  int unsigned mem [int unsigned];
  int unsigned rd_calls;
  int unsigned wr_calls;
  int unsigned rd_log [$];
  int unsigned wr_log [$];

  function automatic int unsigned dpi_pmem_read(input int unsigned addr);
    rd_calls++;
    rd_log.push_back(addr);
    return mem.exists(addr) ? mem[addr] : '0;
  endfunction

  function automatic void dpi_pmem_write(input int unsigned addr, input int unsigned data,
                                         input byte unsigned mask);
    int unsigned word;
    wr_calls++;
    wr_log.push_back(addr);
    word = mem.exists(addr) ? mem[addr] : '0;
    for (int unsigned b = 0; b < 4; b++)
      if (mask[b]) word[8*b +: 8] = data[8*b +: 8];
    mem[addr] = word;
  endfunction

endpackage

// File: rtl/pmem_hs_ctrl_lfsr.sv
// pmem_lfsr: 4-bit Fibonacci LFSR, x^4+x^3+1, reseeded on reset and stepping every cycle.
module pmem_lfsr
  import pmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= LFSR_SEED;
    else     q <= {q[2:0], q[3] ^ q[2]};
  end

endmodule

// File: rtl/pmem_hs_ctrl.sv
// pmem_hs_ctrl: valid/ready front end to a word-addressed pmem model with fixed access latency.
// PMEM_RAND_DELAY_EN adds 0..3 pseudo-random BUSY cycles per request.
module pmem_hs_ctrl
  import pmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wmask,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int unsigned LANES = DATA_W / 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(MASK_W);
  localparam int unsigned CNT_W = 5;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    extra;
  logic                lat_wen;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [MASK_W-1:0]   lat_wmask;
  logic                accept;
  logic                access;
  logic                misaligned;

`ifdef PMEM_RAND_DELAY_EN
  logic [3:0] lfsr;

  pmem_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign extra = CNT_W'(lfsr[1:0]);
`else
  assign extra = '0;
`endif

  assign misaligned = |lat_addr[OFF_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    access     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          access   = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Memory calls happen only on the access edge, so a reset while BUSY never lets a write through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      lat_wen    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_wen   <= req_wen;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wmask <= req_wmask;
        cnt       <= CNT_W'(LATENCY - 1) + extra;
      end else if (state == ST_BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (access) begin
        resp_err   <= misaligned;
        resp_rdata <= '0;
        if (!misaligned) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (lat_wen)
              dpi_pmem_write(32'(lat_addr) + 32'(4 * i), lat_wdata[32*i +: 32],
                             {4'b0000, lat_wmask[4*i +: 4]});
            else
              resp_rdata[32*i +: 32] <= dpi_pmem_read(32'(lat_addr) + 32'(4 * i));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pmem_hs_ctrl.sv
// Bench for pmem_hs_ctrl: 32-bit/LAT2, 64-bit/LAT2 and 32-bit/LAT3 instances sharing the pmem model.
module tb_pmem_hs_ctrl;
  import pmem_pkg::*;

`ifdef PMEM_RAND_DELAY_EN
  localparam int unsigned XMAX = 3;
`else
  localparam int unsigned XMAX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic        req_wen;
  logic        resp_ready;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic [2:0]  rdy, rv, re;
  logic [31:0] rd_a, rd_c;
  logic [63:0] rd_b;

  always #5 clk = ~clk;

  pmem_hs_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(rdy[0]), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_wmask(req_wmask[3:0]),
    .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_rdata(rd_a), .resp_err(re[0]));

  pmem_hs_ctrl #(.ADDR_W(32), .DATA_W(64), .LATENCY(2)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(rdy[1]), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_rdata(rd_b), .resp_err(re[1]));

  pmem_hs_ctrl #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(rdy[2]), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_wmask(req_wmask[3:0]),
    .resp_valid(rv[2]), .resp_ready(resp_ready), .resp_rdata(rd_c), .resp_err(re[2]));

  int unsigned sel;
  logic        o_ready, o_valid, o_err;
  logic [63:0] o_rdata;

  always_comb begin
    o_ready = rdy[sel];
    o_valid = rv[sel];
    o_err   = re[sel];
    case (sel)
      0:       o_rdata = {32'h0, rd_a};
      1:       o_rdata = rd_b;
      default: o_rdata = {32'h0, rd_c};
    endcase
  end

  int unsigned n_chk, n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference memory: word map with byte-mask merge done arithmetically.
  int unsigned ref_mem [int unsigned];

  function automatic int unsigned ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 0;
  endfunction

  function automatic void ref_wr(input int unsigned a, input int unsigned d, input logic [3:0] m);
    int unsigned w;
    int unsigned bm;
    w = ref_rd(a);
    for (int b = 0; b < 4; b++) begin
      bm = 32'hFF << (8 * b);
      if (m[b]) w = (w & ~bm) | (d & bm);
    end
    ref_mem[a] = w;
  endfunction

  task automatic preload(input int unsigned a, input int unsigned d);
    dpi_pmem_write(a, d, 8'h0F);
    ref_wr(a, d, 4'hF);
  endtask

  // One complete request/response on instance s; called and returns at a negedge.
  task automatic txn(input int unsigned s, input logic wen, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wmask, input int unsigned stall,
                     input logic [63:0] exp_rdata, input logic exp_err, input string name);
    int unsigned lanes, lat, rd0, wr0, n;
    logic [63:0] held;
    sel   = s;
    lanes = (s == 1) ? 2 : 1;
    lat   = (s == 2) ? 3 : 2;
    rd0   = rd_calls;
    wr0   = wr_calls;
    #1;
    chk({name, " ready_idle"}, o_ready, 1);
    req_valid    = 3'b000;
    req_valid[s] = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_wmask    = wmask;
    @(posedge clk);
    @(negedge clk);
    chk({name, " ready_busy"}, o_ready, 0);
    req_wen   = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};
    req_wmask = 8'($urandom);
    n = 0;
    while (!o_valid && n < lat + XMAX + 4) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({name, " latency_in_range"}, (n >= lat && n <= lat + XMAX), 1);
    chk({name, " resp_valid"}, o_valid, 1);
    chk({name, " rdata"}, o_rdata, exp_rdata);
    chk({name, " err"}, o_err, exp_err);
    chk({name, " read_calls"}, rd_calls - rd0, (exp_err || wen) ? 0 : lanes);
    chk({name, " write_calls"}, wr_calls - wr0, (exp_err || !wen) ? 0 : lanes);
    held = o_rdata;
    for (int i = 0; i < int'(stall); i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({name, " stall_valid"}, o_valid, 1);
      chk({name, " stall_rdata"}, o_rdata, held);
      chk({name, " stall_ready"}, o_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 3'b000;
    chk({name, " valid_after_take"}, o_valid, 0);
    chk({name, " ready_after_take"}, o_ready, 1);
    chk({name, " no_extra_calls"}, (rd_calls - rd0) + (wr_calls - wr0), exp_err ? 0 : lanes);
    if (wen && !exp_err)
      for (int i = 0; i < int'(lanes); i++)
        ref_wr(addr + 32'(4 * i), wdata[32*i +: 32], wmask[4*i +: 4]);
  endtask

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int unsigned stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic        w, e;
    logic [31:0] a, d;
    logic [3:0]  m;
    int unsigned wr0;

    n_chk = 0; n_err = 0; sel = 0;
    rst = 1'b1; req_valid = '0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;

    tbl[0]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0};
    tbl[1]  = '{1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'hF, 0, 32'h0,         1'b0};
    tbl[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h3, 0, 32'h0,         1'b0};
    tbl[3]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hAABB_3344, 1'b0};
    tbl[4]  = '{1'b0, 32'h8000_0002, 32'h0,         4'h0, 0, 32'h0,         1'b1};
    tbl[5]  = '{1'b1, 32'h8000_0001, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         1'b1};
    tbl[6]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 1, 32'h0,         1'b0};
    tbl[7]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 5, 32'hAABB_3344, 1'b0};
    tbl[8]  = '{1'b1, 32'h8000_0020, 32'h1234_5678, 4'hC, 0, 32'h0,         1'b0};
    tbl[9]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 0, 32'h1234_0000, 1'b0};
    tbl[10] = '{1'b0, 32'h8000_0003, 32'h0,         4'h0, 2, 32'h0,         1'b1};
    tbl[11] = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 2, 32'hDEAD_BEEF, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset req_ready", rdy, 3'b111);
    chk("reset resp_valid", rv, 3'b000);
    chk("reset resp_err", re, 3'b000);
    chk("reset rdata_a", rd_a, 0);
    chk("reset rdata_b", rd_b, 0);

    preload(32'h8000_0000, 32'hDEAD_BEEF);
    for (int i = 0; i < 12; i++)
      txn(0, tbl[i].wen, tbl[i].addr, {32'h0, tbl[i].wdata}, {4'h0, tbl[i].wmask},
          tbl[i].stall, {32'h0, tbl[i].exp_rdata}, tbl[i].exp_err, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      a = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      d = $urandom;
      m = 4'($urandom_range(0, 15));
      e = (a[1:0] != 2'b00);
      txn(0, w, a, {32'h0, d}, {4'h0, m}, $urandom_range(0, 3),
          (w || e) ? 64'h0 : {32'h0, ref_rd(a)}, e, $sformatf("rnd%0d", i));
    end

    preload(32'h8000_0108, 32'h1111_1111);
    preload(32'h8000_010C, 32'h2222_2222);
    txn(1, 1'b0, 32'h8000_0108, 64'h0, 8'h00, 0, 64'h2222_2222_1111_1111, 1'b0, "rd64");
    chk("rd64 lane0 addr", rd_log[rd_log.size() - 2], 32'h8000_0108);
    chk("rd64 lane1 addr", rd_log[rd_log.size() - 1], 32'h8000_010C);
    txn(1, 1'b1, 32'h8000_0108, 64'hAAAA_AAAA_BBBB_BBBB, 8'hF0, 0, 64'h0, 1'b0, "wr64_mask0_lane");
    chk("wr64 lane0 addr", wr_log[wr_log.size() - 2], 32'h8000_0108);
    chk("wr64 lane1 addr", wr_log[wr_log.size() - 1], 32'h8000_010C);
    txn(1, 1'b0, 32'h8000_0108, 64'h0, 8'h00, 1, 64'hAAAA_AAAA_1111_1111, 1'b0, "rd64_after_wr");
    txn(1, 1'b0, 32'h8000_0104, 64'h0, 8'h00, 0, 64'h0, 1'b1, "rd64_misaligned");

    txn(2, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 0, 64'hDEAD_BEEF, 1'b0, "rd_lat3");

    sel = 2;
    wr0 = wr_calls;
    req_valid = 3'b100; req_wen = 1'b1; req_addr = 32'h8000_0200;
    req_wdata = 64'h5A5A_5A5A; req_wmask = 8'h0F;
    @(posedge clk);
    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async reset ready", o_ready, 1);
    chk("async reset valid", o_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("post reset valid", o_valid, 0);
    end
    chk("post reset ready", o_ready, 1);
    chk("post reset rdata", o_rdata, 0);
    chk("abandoned write calls", wr_calls - wr0, 0);
    txn(2, 1'b0, 32'h8000_0200, 64'h0, 8'h00, 0, {32'h0, ref_rd(32'h8000_0200)}, 1'b0,
        "abandoned write not in memory");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
